receiver_calc: RTL and testbench
================================

Name: receiver_calc

Overview:
- Receive-side counterpart of the calculator transmit path.
- Deserialises 8N1 UART bytes from rxd_pin and reassembles them MSB-byte-first into a DATASIZE-bit message word, the same layout the transmit path splits.
- Presents each completed message with a one-cycle valid strobe to the downstream calculator logic.
- Contains its own oversampling RX bit engine and the byte-packing FSM; no external UART core.

Parameters:
- DATASIZE, 128, message width in bits; must be a multiple of 8. MAXB = DATASIZE/8 bytes.
- CLK_HZ, 100_000_000, clock frequency in Hz.
- BIT_RATE, 9_600, UART baud. CPB = CLK_HZ/BIT_RATE, integer division (10416 at defaults).
- TERMINATOR, 8'h0D, byte that closes a message.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rxd_pin  in  1  UART receive pin, idle high, asynchronous to clk.
- data  out  DATASIZE  last completed message, right-justified, zero-padded at the top.
- msg_valid  out  1  one-cycle pulse: data updated this cycle.
- byte_count  out  $clog2(MAXB)+1  number of bytes in the last completed message.
- frame_err  out  1  sticky: a byte had stop bit = 0.
- led  out  4  [0] RX FSM not IDLE, [1] toggles on each msg_valid, [2] reset, [3] synchronised rxd.

Behaviour:
- Reset values:
  - data = 0, msg_valid = 0, byte_count = 0, frame_err = 0, led[1] = 0.
  - Synchroniser flops = 1; RX FSM = IDLE; accumulator and count cleared.
- Synchroniser: rxd_pin passes through two flops. All decisions use the second flop (rxs).
- Arming: after reset, start detection is armed only once rxs has been sampled high. A line held low through reset release never produces a byte.
- RX FSM, with bit counter 0..CPB-1:
  - IDLE: on rxs 1->0, go to START with counter = 0.
  - START: at counter = CPB/2, sample rxs.
    - rxs = 0: go to DATA, reset counter.
    - rxs = 1 (glitch): return to IDLE, no byte.
  - DATA: every CPB cycles, sample 8 bits LSB first into the shift register; after bit 7, go to STOP.
  - STOP: after CPB cycles, sample rxs.
    - rxs = 1: byte valid, pass to the packer.
    - rxs = 0: byte discarded, frame_err <= 1, wait in STOP until rxs = 1, then IDLE.
  - The bit engine returns to IDLE in the cycle after the stop sample.
- Packer, on each valid byte b:
  - acc <= {acc[DATASIZE-9:0], b}; cnt <= cnt + 1.
  - The message completes when b == TERMINATOR or cnt + 1 == MAXB. The terminator is stored in the word.
  - On completion: data <= shifted acc, byte_count <= cnt + 1, msg_valid = 1 for one cycle. This happens the cycle after the stop-bit sample.
  - In the same cycle acc and cnt clear, so the next byte starts a new message.
- Length limit: a stream with no TERMINATOR completes every MAXB bytes. There is no overflow state.
- Between messages, data and byte_count hold their last value.
- Reset mid-byte or mid-message: everything returns to reset values immediately; partial byte and partial message are lost.

Optional Feature:
- Macro: RX_NUL_FILTER_EN.
- Defined: valid bytes equal to 8'h00 are dropped before the packer (not shifted in, not counted). Leading zero padding sent by the transmit path therefore does not count toward byte_count.
- Undefined: 8'h00 is packed and counted like any other byte.
- data is identical in both builds for zero-padded messages; byte_count differs.

Test Plan:
1. 16-byte frame: 4x 8'h00, "CALCULATOR", 8'h0A, 8'h0D at 9600 baud -> exactly one msg_valid, data = {32'h0,"CALCULATOR",8'h0A,8'h0D}, byte_count = 16 (12 with RX_NUL_FILTER_EN), frame_err = 0.
2. "12+3", 8'h0D -> msg_valid one cycle after the last stop sample, data = {88'h0,"12+3",8'h0D}, byte_count = 5.
3. 17 bytes 8'h41, no terminator -> msg_valid after byte 16 with data = {16{8'h41}} and byte_count = 16; 17th byte starts a new message, no second strobe.
4. Byte 8'h55 sent with stop bit = 0 -> frame_err = 1 and stays 1, byte not packed. Following "7", 8'h0D -> data = {112'h0,"7",8'h0D}.
5. Low glitch of 3000 cycles (< CPB/2) on an idle line -> no byte, FSM back in IDLE, led[0] = 0.
6. Assert reset for 1 cycle in the middle of a byte -> all outputs 0 next cycle. The next full "9", 8'h0D -> data = {112'h0,"9",8'h0D}, byte_count = 2.

Source files
------------

// File: rtl/receiver_calc.sv
// receiver_calc: UART (8N1) receive path for the calculator link.
// An oversampling bit engine recovers bytes from rxd_pin, and a packer
// assembles them MSB-byte-first into a DATASIZE-bit message word. A message
// closes on TERMINATOR or when MAXB bytes have been collected.
// Optional build macro: RX_NUL_FILTER_EN -- when defined, received 8'h00
// bytes are dropped before the packer (not stored, not counted).
module receiver_calc #(
    parameter int unsigned DATASIZE   = 128,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BIT_RATE   = 9_600,
    parameter logic [7:0]  TERMINATOR = 8'h0D
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rxd_pin,
    output logic [DATASIZE-1:0]             data,
    output logic                            msg_valid,
    output logic [$clog2(DATASIZE/8):0]     byte_count,
    output logic                            frame_err,
    output logic [3:0]                      led
);

    localparam int unsigned MAXB = DATASIZE / 8;
    localparam int unsigned CW   = $clog2(MAXB) + 1;
    localparam int unsigned CPB  = CLK_HZ / BIT_RATE;
    localparam int unsigned CTW  = (CPB > 2) ? $clog2(CPB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Synchroniser and start-detection arming
    // ------------------------------------------------------------------
    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_sv;        // r_sv[1]: r_sync2 holds a genuine pin sample
    logic       r_armed;
    logic       r_rxs_prev;
    logic       w_rxs;
    logic       w_fall;

    assign w_rxs  = r_sync2;
    // The flops reset to 1, so only a real high sample (not the reset value)
    // may arm start detection; a line held low through reset stays ignored.
    assign w_fall = r_armed && r_rxs_prev && !w_rxs;

    // Two-flop synchroniser, previous-sample register and arming flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sv       <= 2'b00;
            r_armed    <= 1'b0;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd_pin;
            r_sync2    <= r_sync1;
            r_sv       <= {r_sv[0], 1'b1};
            r_rxs_prev <= r_sync2;
            if (r_sv[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX bit engine
    // ------------------------------------------------------------------
    rx_state_t      r_state;
    logic [CTW-1:0] r_bit_cnt;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_stop_hold;   // bad stop bit seen, waiting for line high
    logic           r_frame_err;
    logic           w_stop_tick;
    logic           w_byte_ok;

    assign w_stop_tick = (r_state == ST_STOP) && !r_stop_hold &&
                         (r_bit_cnt == CTW'(CPB - 1));
    assign w_byte_ok   = w_stop_tick && w_rxs;

    // Bit-engine FSM: start validation at mid-bit, 8 data bits LSB first, stop check
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_stop_hold <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt   <= '0;
                    r_stop_hold <= 1'b0;
                    if (w_fall) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_bit_cnt == CTW'(CPB / 2)) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_bit_cnt == CTW'(CPB - 1)) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_stop_hold) begin
                        if (w_rxs) begin
                            r_stop_hold <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end else if (r_bit_cnt == CTW'(CPB - 1)) begin
                        r_bit_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_stop_hold <= 1'b1;
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte packer
    // ------------------------------------------------------------------
    logic [DATASIZE-1:0] r_acc;
    logic [CW-1:0]       r_cnt;
    logic [DATASIZE-1:0] r_data;
    logic [CW-1:0]       r_byte_count;
    logic                r_msg_valid;
    logic                r_led_tog;
    logic                w_pack;
    logic [DATASIZE-1:0] w_acc_next;
    logic [CW-1:0]       w_cnt_next;
    logic                w_done;

`ifdef RX_NUL_FILTER_EN
    assign w_pack = w_byte_ok && (r_shift != 8'h00);
`else
    assign w_pack = w_byte_ok;
`endif

    assign w_acc_next = (r_acc << 8) | DATASIZE'(r_shift);
    assign w_cnt_next = r_cnt + CW'(1);
    assign w_done     = (r_shift == TERMINATOR) || (w_cnt_next == CW'(MAXB));

    // Packing runs on the stop-sample edge itself, so msg_valid is visible
    // in the cycle right after the stop bit is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_data       <= '0;
            r_byte_count <= '0;
            r_msg_valid  <= 1'b0;
            r_led_tog    <= 1'b0;
        end else begin
            r_msg_valid <= 1'b0;
            if (w_pack) begin
                if (w_done) begin
                    r_data       <= w_acc_next;
                    r_byte_count <= w_cnt_next;
                    r_msg_valid  <= 1'b1;
                    r_led_tog    <= ~r_led_tog;
                    r_acc        <= '0;
                    r_cnt        <= '0;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_next;
                end
            end
        end
    end

    assign data       = r_data;
    assign msg_valid  = r_msg_valid;
    assign byte_count = r_byte_count;
    assign frame_err  = r_frame_err;
    assign led        = {w_rxs, reset, r_led_tog, (r_state != ST_IDLE)};

endmodule

// File: tb/tb_receiver_calc.sv
// tb_receiver_calc: self-checking bench for receiver_calc.
// Runs with a reduced CPB (16 clocks per bit) to keep frames short.
module tb_receiver_calc;

    localparam int unsigned DW    = 128;
    localparam int unsigned CLKHZ = 1_600_000;
    localparam int unsigned BAUD  = 100_000;
    localparam int unsigned CPB   = CLKHZ / BAUD;
    localparam int unsigned MAXB  = DW / 8;
    localparam logic [7:0]  TERM  = 8'h0D;

    logic                      clk     = 1'b0;
    logic                      reset   = 1'b1;
    logic                      rxd_pin = 1'b1;
    logic [DW-1:0]             data;
    logic                      msg_valid;
    logic [$clog2(MAXB):0]     byte_count;
    logic                      frame_err;
    logic [3:0]                led;

    receiver_calc #(
        .DATASIZE   (DW),
        .CLK_HZ     (CLKHZ),
        .BIT_RATE   (BAUD),
        .TERMINATOR (TERM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd_pin    (rxd_pin),
        .data       (data),
        .msg_valid  (msg_valid),
        .byte_count (byte_count),
        .frame_err  (frame_err),
        .led        (led)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    longint      cycle    = 0;
    longint      last_stop_cyc = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [DW-1:0] d;
        int unsigned   c;
        longint        cyc;
    } msg_t;

    msg_t obs_q[$];
    msg_t exp_q[$];
    logic prev_v = 1'b0;

    // Strobe monitor: records every message and checks it is a single-cycle pulse
    always @(negedge clk) begin
        if (msg_valid === 1'b1) begin
            n_checks++;
            if (prev_v === 1'b1) begin
                n_fail++;
                $display("FAIL strobe_width: msg_valid high on consecutive cycles (cycle %0d), required one-cycle pulse", cycle);
            end
            obs_q.push_back('{data, int'(byte_count), cycle});
        end
        prev_v = msg_valid;
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rxd_pin = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd_pin = b[i];
            tick(CPB);
        end
        last_stop_cyc = cycle;
        rxd_pin = stop_ok;
        tick(CPB);
        if (!stop_ok) begin
            rxd_pin = 1'b1;
            tick(CPB);
        end
    endtask

    // ---------------- reference model (message-level) ----------------
    logic [7:0]  cur_q[$];
    bit          model_ferr;
    int unsigned model_strobes;

    task automatic model_reset();
        cur_q.delete();
        exp_q.delete();
        obs_q.delete();
        model_ferr    = 1'b0;
        model_strobes = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [DW-1:0] d;
        int unsigned   n;
        if (!ok) begin
            model_ferr = 1'b1;
            return;
        end
`ifdef RX_NUL_FILTER_EN
        if (b == 8'h00) return;
`endif
        cur_q.push_back(b);
        if (b == TERM || cur_q.size() == MAXB) begin
            d = '0;
            n = cur_q.size();
            for (int i = 0; i < n; i++) d[8*(n-1-i) +: 8] = cur_q[i];
            exp_q.push_back('{d, n, 0});
            model_strobes++;
            cur_q.delete();
        end
    endtask

    task automatic compare_msgs(input string tag);
        check({tag, "_msg_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_data"}, obs_q[i].d, exp_q[i].d);
            check({tag, "_byte_count"}, obs_q[i].c, exp_q[i].c);
        end
        check({tag, "_frame_err"}, frame_err, model_ferr);
        check({tag, "_led1"}, led[1], model_strobes[0]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Reset pulse of one cycle; outputs must read as reset values right after the edge
    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_data", data, '0);
        check("rst_msg_valid", msg_valid, 1'b0);
        check("rst_byte_count", byte_count, '0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_led10", led[1:0], 2'b00);
        check("rst_led2", led[2], 1'b1);
        reset = 1'b0;
        tick(3);
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [16:0][7:0] b;
        int unsigned      n;
        logic [16:0]      bad;
        logic [DW-1:0]    exp_d;
        int unsigned      exp_c;
        int unsigned      exp_n;
        bit               exp_fe;
        bit               chk_lat;
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [79:0] calc;
        logic [7:0]  rb;
        bit          rok;
        longint      lat;

        calc = "CALCULATOR";
        for (int v = 0; v < 4; v++) vt[v] = '0;

        for (int i = 0; i < 4; i++) vt[0].b[i] = 8'h00;
        for (int i = 0; i < 10; i++) vt[0].b[4+i] = calc[8*(9-i) +: 8];
        vt[0].b[14] = 8'h0A;
        vt[0].b[15] = 8'h0D;
        vt[0].n       = 16;
        vt[0].exp_d   = 128'h0000_0000_4341_4C43_554C_4154_4F52_0A0D;
`ifdef RX_NUL_FILTER_EN
        vt[0].exp_c   = 12;
`else
        vt[0].exp_c   = 16;
`endif
        vt[0].exp_n   = 1;
        vt[0].chk_lat = 1'b1;

        vt[1].b[0] = 8'h31; vt[1].b[1] = 8'h32; vt[1].b[2] = 8'h2B;
        vt[1].b[3] = 8'h33; vt[1].b[4] = 8'h0D;
        vt[1].n       = 5;
        vt[1].exp_d   = 128'h31_322B_330D;
        vt[1].exp_c   = 5;
        vt[1].exp_n   = 1;
        vt[1].chk_lat = 1'b1;

        for (int i = 0; i < 17; i++) vt[2].b[i] = 8'h41;
        vt[2].n     = 17;
        vt[2].exp_d = {16{8'h41}};
        vt[2].exp_c = 16;
        vt[2].exp_n = 1;

        vt[3].b[0] = 8'h55; vt[3].b[1] = 8'h37; vt[3].b[2] = 8'h0D;
        vt[3].n       = 3;
        vt[3].bad     = 17'b1;
        vt[3].exp_d   = 128'h370D;
        vt[3].exp_c   = 2;
        vt[3].exp_n   = 1;
        vt[3].exp_fe  = 1'b1;
        vt[3].chk_lat = 1'b1;

        tick(4);
        do_reset();

        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < vt[v].n; i++) begin
                send_byte(vt[v].b[i], !vt[v].bad[i]);
                if (vt[v].exp_fe && i == 0) check($sformatf("vec%0d_ferr_early", v), frame_err, 1'b1);
            end
            tick(2 * CPB);
            check($sformatf("vec%0d_strobes", v), obs_q.size(), vt[v].exp_n);
            if (obs_q.size() > 0) begin
                check($sformatf("vec%0d_data", v), obs_q[0].d, vt[v].exp_d);
                check($sformatf("vec%0d_byte_count", v), obs_q[0].c, vt[v].exp_c);
                if (vt[v].chk_lat) begin
                    lat = obs_q[obs_q.size()-1].cyc - last_stop_cyc;
                    check($sformatf("vec%0d_latency_in_stop_bit", v),
                          (lat > 0 && lat <= longint'(CPB)), 1'b1);
                end
            end
            check($sformatf("vec%0d_frame_err", v), frame_err, vt[v].exp_fe);
            check($sformatf("vec%0d_led1", v), led[1], vt[v].exp_n[0]);
        end

        // Short low glitch on idle line: no byte, FSM returns to idle
        do_reset();
        tick(CPB);
        rxd_pin = 1'b0;
        tick(4);
        check("glitch_led0_busy", led[0], 1'b1);
        rxd_pin = 1'b1;
        tick(CPB);
        check("glitch_led0_idle", led[0], 1'b0);
        check("glitch_no_msg", obs_q.size(), 0);
        send_byte(TERM, 1'b1);
        tick(CPB);
        check("glitch_next_msgs", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            check("glitch_next_data", obs_q[0].d, 128'h0D);
            check("glitch_next_count", obs_q[0].c, 1);
        end

        // Reset in the middle of a byte, with a partial message pending
        do_reset();
        send_byte(8'h35, 1'b1);
        send_byte(TERM, 1'b1);
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        rxd_pin = 1'b0;
        tick(CPB);
        rxd_pin = 1'b1;          // 8'hFF data bits: line stays high after the start bit
        tick(4 * CPB + CPB / 2);
        check("midbyte_led0_busy", led[0], 1'b1);
        check("midbyte_data_before", data, 128'h350D);
        do_reset();
        tick(6 * CPB);
        send_byte(8'h39, 1'b1);
        send_byte(TERM, 1'b1);
        tick(2 * CPB);
        check("midbyte_after_msgs", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            check("midbyte_after_data", obs_q[0].d, 128'h390D);
            check("midbyte_after_count", obs_q[0].c, 2);
        end
        check("midbyte_after_ferr", frame_err, 1'b0);

        // Randomised stream against the message-level model
        do_reset();
        for (int k = 0; k < 60; k++) begin
            int unsigned r;
            r = $urandom_range(0, 15);
            if (r < 3)      rb = TERM;
            else if (r < 5) rb = 8'h00;
            else            rb = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 11) != 0);
            send_byte(rb, rok);
            model_byte(rb, rok);
            tick($urandom_range(0, 3));
        end
        tick(2 * CPB);
        compare_msgs("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
